// File: rtl/sdram_arbit.sv
// Command-bus arbiter for the SDRAM controller: the init sequencer owns the bus
// until init_end, then refresh has priority and write/read alternate on ties.
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARBIT = 3'd1;
    localparam logic [2:0] AREF  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] READ  = 3'd4;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    logic [2:0]        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [3:0]        cmd_s;
    logic [BA_W-1:0]   ba_s;
    logic [ADDR_W-1:0] addr_s;

    // Next-state decision and last data-grant tracking (refresh leaves it alone)
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                if (init_end) state_d = ARBIT;
                else          state_d = IDLE;
            end
            ARBIT: begin
                if (aref_req)              state_d = AREF;
                else if (wr_req && rd_req) state_d = last_wr_q ? READ : WRITE;
                else if (wr_req)           state_d = WRITE;
                else if (rd_req)           state_d = READ;
                else                       state_d = ARBIT;
                if (state_d == WRITE)     last_wr_d = 1'b1;
                else if (state_d == READ) last_wr_d = 1'b0;
                else                      last_wr_d = last_wr_q;
            end
            AREF: begin
                if (aref_end) state_d = ARBIT;
                else          state_d = AREF;
            end
            WRITE: begin
                if (wr_end) state_d = ARBIT;
                else        state_d = WRITE;
            end
            READ: begin
                if (rd_end) state_d = ARBIT;
                else        state_d = READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and last-grant registers; reset leaves READ as the last grant so the first tie goes to WRITE
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Command/address mux selected by the current owner of the bus
    always_comb begin
        cmd_s  = CMD_NOP;
        ba_s   = {BA_W{1'b1}};
        addr_s = {ADDR_W{1'b1}};
        case (state_q)
            IDLE: begin
                cmd_s  = init_cmd;
                ba_s   = init_ba;
                addr_s = init_addr;
            end
            AREF: begin
                cmd_s  = aref_cmd;
                ba_s   = aref_ba;
                addr_s = aref_addr;
            end
            WRITE: begin
                cmd_s  = wr_cmd;
                ba_s   = wr_ba;
                addr_s = wr_addr;
            end
            READ: begin
                cmd_s  = rd_cmd;
                ba_s   = rd_ba;
                addr_s = rd_addr;
            end
            default: begin
                cmd_s  = CMD_NOP;
                ba_s   = {BA_W{1'b1}};
                addr_s = {ADDR_W{1'b1}};
            end
        endcase
    end

    // Grants follow the state register directly so a reset drops them without a clock
    assign aref_en = (state_q == AREF);
    assign wr_en   = (state_q == WRITE);
    assign rd_en   = (state_q == READ);

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;
    assign sdram_ba    = ba_s;
    assign sdram_addr  = addr_s;
    assign sdram_dq_oe  = wr_en & wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboarded random bench for sdram_arbit: grant order predicted per request
// batch from the priority rules, compared by a negedge monitor.
module tb_sdram_arbit;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DATA_W = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              aref_req, aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              aref_en, wr_en, rd_en, sdram_cke;
    logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    int total = 0;
    int bad   = 0;
    bit mon_on   = 1'b0;
    bit drv_rand = 1'b1;
    bit last_was_wr = 1'b0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_g = 3'b000;

    sdram_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
        .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [18:0] bus_out();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    endfunction

    function automatic logic en_of(input int idx);
        case (idx)
            0:       return aref_en;
            1:       return wr_en;
            default: return rd_en;
        endcase
    endfunction

    task automatic set_req(input int idx, input logic v);
        case (idx)
            0:       aref_req = v;
            1:       wr_req   = v;
            default: rd_req   = v;
        endcase
    endtask

    task automatic set_end(input int idx, input logic v);
        case (idx)
            0:       aref_end = v;
            1:       wr_end   = v;
            default: rd_end   = v;
        endcase
    endtask

    // Source agent: hold request until granted, run a random burst, pulse end
    task automatic serve(input int idx);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 300) begin
            @(posedge sys_clk); #1;
            n++;
            got = en_of(idx);
        end
        set_req(idx, 1'b0);
        if (!got) begin
            fail_now($sformatf("grant_wait_src%0d", idx));
        end else begin
            repeat ($urandom_range(2, 8)) begin
                @(posedge sys_clk); #1;
            end
            set_end(idx, 1'b1);
            @(posedge sys_clk); #1;
            set_end(idx, 1'b0);
        end
    endtask

    // Raises refresh one cycle into the first data burst, then serves it
    task automatic inject();
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 300) begin
            @(posedge sys_clk); #1;
            n++;
            got = wr_en | rd_en;
        end
        if (!got) begin
            fail_now("inject_wait");
        end else begin
            @(posedge sys_clk); #1;
            aref_req = 1'b1;
            serve(0);
        end
    endtask

    // Random write-data driver
    initial begin
        forever begin
            @(posedge sys_clk); #1;
            if (drv_rand) begin
                wr_sdram_en   = 1'($urandom);
                wr_sdram_data = DATA_W'($urandom);
            end
        end
    end

    // Monitor: grant order, one-hot, NOP gap, bus mux and DQ drive
    always @(negedge sys_clk) begin
        if (mon_on) begin
            logic [2:0] g;
            g = {rd_en, wr_en, aref_en};
            chk("grant_onehot", 32'($countones(g) <= 1), 32'd1);
            if (g != 3'b000 && prev_g == 3'b000) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    chk("grant_order", 32'(g), 32'(exp_q.pop_front()));
                end
            end
            if (g != 3'b000 && g != prev_g)
                chk("nop_gap", 32'(prev_g), 32'd0);
            case (g)
                3'b000:  chk("bus_nop", 32'(bus_out()), 32'h3FFFF);
                3'b001:  chk("bus_aref", 32'(bus_out()), 32'({aref_cmd, aref_ba, aref_addr}));
                3'b010:  chk("bus_wr", 32'(bus_out()), 32'({wr_cmd, wr_ba, wr_addr}));
                default: chk("bus_rd", 32'(bus_out()), 32'({rd_cmd, rd_ba, rd_addr}));
            endcase
            chk("dq_oe", 32'(sdram_dq_oe), 32'(wr_en & wr_sdram_en));
            chk("dq_out", 32'(sdram_dq_out), (wr_en & wr_sdram_en) ? 32'(wr_sdram_data) : 32'd0);
            chk("cke", 32'(sdram_cke), 32'd1);
            prev_g = g;
        end
    end

    initial begin
        logic [2:0] mask;
        bit inj;
        logic [2:0] first_d, second_d;
        int n;
        bit got;

        sys_rst_n = 1'b0;
        init_end = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
        aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0000;
        wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123;
        rd_cmd = 4'b0101; rd_ba = 2'b11; rd_addr = 13'h0456;
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h0000;

        #2;
        chk("rst_bus_init", 32'(bus_out()), 32'({init_cmd, init_ba, init_addr}));
        chk("rst_grants", 32'({rd_en, wr_en, aref_en}), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Initialisation phase: bus follows the init sequencer
        for (int c = 0; c < 100; c++) begin
            @(posedge sys_clk); #1;
            if (c > 0) begin
                init_cmd  = 4'($urandom);
                init_ba   = 2'($urandom);
                init_addr = 13'($urandom);
            end
            #2;
            chk("init_bus", 32'(bus_out()), 32'({init_cmd, init_ba, init_addr}));
            chk("init_grants", 32'({rd_en, wr_en, aref_en}), 32'd0);
            chk("init_cke", 32'(sdram_cke), 32'd1);
        end

        // init_end at N with refresh pending
        @(posedge sys_clk); #1;
        init_end = 1'b1;
        aref_req = 1'b1;
        @(posedge sys_clk); #1;
        chk("arbit_nop_cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
        chk("arbit_no_grant", 32'(aref_en), 32'd0);
        @(posedge sys_clk); #1;
        chk("aref_en_n2", 32'(aref_en), 32'd1);
        aref_req = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            @(posedge sys_clk); #1;
            chk("aref_en_held", 32'(aref_en), 32'd1);
            if (i == 10) aref_end = 1'b1;
        end
        @(posedge sys_clk); #1;
        aref_end = 1'b0;
        chk("aref_en_drop", 32'(aref_en), 32'd0);
        chk("aref_back_nop", 32'(bus_out()), 32'h3FFFF);
        init_end = 1'b0;  // later deassertion must be ignored

        @(negedge sys_clk);
        prev_g = 3'b000;
        mon_on = 1'b1;

        for (int r = 0; r < 40; r++) begin
            @(posedge sys_clk); #1;
            mask = 3'($urandom_range(1, 7));
            inj  = (!mask[0]) && (mask[2:1] != 2'b00) && ($urandom_range(0, 2) == 0);
            if (r == 0) begin mask = 3'b110; inj = 1'b0; end
            if (r == 1) begin mask = 3'b111; inj = 1'b0; end
            if (r == 2) begin mask = 3'b110; inj = 1'b1; end
            aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
            wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 13'($urandom);
            rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 13'($urandom);

            // Expected grant sequence for this batch of requests
            if (mask[0]) exp_q.push_back(3'b001);
            first_d = 3'b000; second_d = 3'b000;
            if (mask[1] && mask[2]) begin
                first_d  = last_was_wr ? 3'b100 : 3'b010;
                second_d = last_was_wr ? 3'b010 : 3'b100;
            end else if (mask[1]) begin
                first_d = 3'b010;
            end else if (mask[2]) begin
                first_d = 3'b100;
            end
            if (first_d != 3'b000) exp_q.push_back(first_d);
            if (inj) exp_q.push_back(3'b001);
            if (second_d != 3'b000) exp_q.push_back(second_d);
            if (second_d != 3'b000) last_was_wr = (second_d == 3'b010);
            else if (first_d != 3'b000) last_was_wr = (first_d == 3'b010);

            aref_req = mask[0];
            wr_req   = mask[1];
            rd_req   = mask[2];
            fork
                if (mask[0]) serve(0);
                if (mask[1]) serve(1);
                if (mask[2]) serve(2);
                if (inj) inject();
            join
            repeat (2) @(posedge sys_clk);
        end

        @(negedge sys_clk);
        mon_on = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Write with fixed data, then reset mid-burst
        drv_rand = 1'b0;
        @(posedge sys_clk); #1;
        wr_req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
            got = wr_en;
        end
        wr_req = 1'b0;
        if (!got) fail_now("final_wr_grant");
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hA5A5;
        #1;
        chk("dq_oe_a5", 32'(sdram_dq_oe), 32'd1);
        chk("dq_out_a5", 32'(sdram_dq_out), 32'h0000A5A5);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst_async_oe", 32'(sdram_dq_oe), 32'd0);
        chk("rst_async_wr_en", 32'(wr_en), 32'd0);
        chk("rst_async_dq", 32'(sdram_dq_out), 32'd0);
        chk("rst_async_bus", 32'(bus_out()), 32'({init_cmd, init_ba, init_addr}));
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        chk("post_rst_idle", 32'(bus_out()), 32'({init_cmd, init_ba, init_addr}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
